// File: rtl/axi_full_s_mem.sv
// AXI4 full slave with an internal word-addressed register memory.
// One transaction in flight per direction. The read and write channels run
// independently of each other.
// Optional feature: define AXI_S_WRAP_BURST_EN to accept WRAP bursts of
// length 2/4/8/16. When it is undefined, every WRAP burst gets SLVERR.
module axi_full_s_mem #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_MEM_DEPTH_LOG2 = 8
) (
  input  logic                            i_sysclk,
  input  logic                            i_sysrst,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int ADDR_LSB = $clog2(C_S_AXI_DATA_WIDTH / 8);
  localparam int IW       = C_S_MEM_DEPTH_LOG2;
  localparam int DEPTH    = 1 << IW;
  localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;

`ifdef AXI_S_WRAP_BURST_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [IW-1:0] idx_t;

  // A burst is rejected if the burst type is reserved, if the beat size is not
  // the full bus width, or if it is a WRAP burst that this build cannot serve.
  function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size,
                                     input logic [7:0] len);
    logic err;
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    err = (size != 3'(ADDR_LSB)) || (burst == 2'b11);
    if (burst == 2'b10 && !(WRAP_EN && wrap_len_ok)) err = 1'b1;
    return err;
  endfunction

  // This returns the word index of the next beat. WRAP keeps the upper index bits
  // and wraps the low bits inside a block of (len+1) words. The block is aligned.
  function automatic idx_t next_idx(input idx_t idx, input logic [1:0] burst,
                                    input logic [7:0] len);
    idx_t mask;
    idx_t inc;
    mask = idx_t'(len);
    inc  = idx + idx_t'(1);
    case (burst)
      2'b01:   return inc;
      2'b10:   return (idx & ~mask) | (inc & mask);
      default: return idx;
    endcase
  endfunction

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

  // Only the address bits that select a word are decoded. All other bits alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR};

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t                     wstate;
  logic [C_S_AXI_ID_WIDTH-1:0] aw_id;
  idx_t                        w_idx;
  logic [7:0]                  aw_len;
  logic [7:0]                  w_cnt;
  logic [1:0]                  aw_burst;
  logic                        aw_err;
  logic                        wlast_err;
  logic                        w_beat;
  logic                        w_final;
  logic                        w_we;

  assign w_beat  = S_AXI_WREADY && S_AXI_WVALID;
  assign w_final = (w_cnt == aw_len);
  assign w_we    = w_beat && !aw_err && !i_sysrst;

  // Write FSM: accept the address, then take len+1 data beats, then hold the response until it is accepted.
  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      wstate        <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BID     <= '0;
      S_AXI_BRESP   <= RESP_OKAY;
    end else begin
      case (wstate)
        W_IDLE: begin
          S_AXI_AWREADY <= 1'b1;
          if (S_AXI_AWREADY && S_AXI_AWVALID) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b1;
            aw_id         <= S_AXI_AWID;
            w_idx         <= S_AXI_AWADDR[ADDR_LSB +: IW];
            aw_len        <= S_AXI_AWLEN;
            aw_burst      <= S_AXI_AWBURST;
            aw_err        <= burst_err(S_AXI_AWBURST, S_AXI_AWSIZE, S_AXI_AWLEN);
            w_cnt         <= 8'd0;
            wlast_err     <= 1'b0;
            wstate        <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_idx <= next_idx(w_idx, aw_burst, aw_len);
            w_cnt <= w_cnt + 8'd1;
            if (w_final) begin
              S_AXI_WREADY <= 1'b0;
              S_AXI_BVALID <= 1'b1;
              S_AXI_BID    <= aw_id;
              S_AXI_BRESP  <= (aw_err || wlast_err || !S_AXI_WLAST) ? RESP_SLVERR : RESP_OKAY;
              wstate       <= W_RESP;
            end else if (S_AXI_WLAST) begin
              wlast_err <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            wstate        <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Byte-enabled memory write. The memory contents are never cleared.
  always_ff @(posedge i_sysclk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (w_we && S_AXI_WSTRB[b]) mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
    end
  end

  rstate_t    rstate;
  idx_t       r_idx;
  idx_t       ar_idx0;
  logic [7:0] ar_len;
  logic [7:0] r_cnt;
  logic [1:0] ar_burst;
  logic       ar_err;
  logic       ar_err_new;

  assign ar_idx0    = S_AXI_ARADDR[ADDR_LSB +: IW];
  assign ar_err_new = burst_err(S_AXI_ARBURST, S_AXI_ARSIZE, S_AXI_ARLEN);

  // Read FSM: the beat being presented is held in the R registers. The next beat is loaded when the current one is taken.
  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      rstate        <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RLAST   <= 1'b0;
      S_AXI_RID     <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RDATA   <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          S_AXI_ARREADY <= 1'b1;
          if (S_AXI_ARREADY && S_AXI_ARVALID) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_RID     <= S_AXI_ARID;
            S_AXI_RRESP   <= ar_err_new ? RESP_SLVERR : RESP_OKAY;
            S_AXI_RDATA   <= ar_err_new ? '0 : mem[ar_idx0];
            S_AXI_RLAST   <= (S_AXI_ARLEN == 8'd0);
            r_idx         <= ar_idx0;
            ar_len        <= S_AXI_ARLEN;
            ar_burst      <= S_AXI_ARBURST;
            ar_err        <= ar_err_new;
            r_cnt         <= 8'd0;
            rstate        <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            if (S_AXI_RLAST) begin
              S_AXI_RVALID  <= 1'b0;
              S_AXI_RLAST   <= 1'b0;
              S_AXI_ARREADY <= 1'b1;
              rstate        <= R_IDLE;
            end else begin
              r_idx       <= next_idx(r_idx, ar_burst, ar_len);
              r_cnt       <= r_cnt + 8'd1;
              S_AXI_RDATA <= ar_err ? '0 : mem[next_idx(r_idx, ar_burst, ar_len)];
              S_AXI_RLAST <= ((r_cnt + 8'd1) == ar_len);
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_full_s_mem.sv
// Directed bench for axi_full_s_mem. It uses the default parameters: 1-bit ID, 32-bit data and 256 words.
module tb_axi_full_s_mem;

  logic        i_sysclk = 1'b0;
  logic        i_sysrst = 1'b1;
  logic [0:0]  S_AXI_AWID = '0;
  logic [31:0] S_AXI_AWADDR = '0;
  logic [7:0]  S_AXI_AWLEN = '0;
  logic [2:0]  S_AXI_AWSIZE = '0;
  logic [1:0]  S_AXI_AWBURST = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WLAST = 1'b0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [0:0]  S_AXI_BID;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [0:0]  S_AXI_ARID = '0;
  logic [31:0] S_AXI_ARADDR = '0;
  logic [7:0]  S_AXI_ARLEN = '0;
  logic [2:0]  S_AXI_ARSIZE = '0;
  logic [1:0]  S_AXI_ARBURST = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [0:0]  S_AXI_RID;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RLAST;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;

  always #5 i_sysclk = ~i_sysclk;

  axi_full_s_mem dut (
    .i_sysclk(i_sysclk), .i_sysrst(i_sysrst),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] wbuf [16];
  logic [31:0] rbuf [16];
  logic [1:0]  rrbuf [16];
  logic        rlbuf [16];
  logic [0:0]  rid_got;

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timeout waiting for handshake", nm);
  endtask

  // One full write burst: data comes from wbuf. wlast_beat < 0 means WLAST is driven correctly on the final beat.
  task automatic do_write(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                          input int wlast_beat, output logic [1:0] resp, output logic [0:0] bid);
    int n;
    resp = 2'bxx;
    bid  = 1'bx;
    @(negedge i_sysclk);
    S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len;
    S_AXI_AWSIZE = size; S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 50) begin @(negedge i_sysclk); n++; end
    if (!S_AXI_AWREADY) begin tmo("aw_handshake"); S_AXI_AWVALID = 1'b0; return; end
    @(negedge i_sysclk);
    S_AXI_AWVALID = 1'b0;
    chk("wready_after_aw", S_AXI_WREADY, 1);
    for (int b = 0; b <= int'(len); b++) begin
      S_AXI_WDATA = wbuf[b]; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
      S_AXI_WLAST = (wlast_beat < 0) ? (b == int'(len)) : (b == wlast_beat);
      n = 0;
      while (!S_AXI_WREADY && n < 50) begin @(negedge i_sysclk); n++; end
      if (!S_AXI_WREADY) begin tmo("w_beat"); S_AXI_WVALID = 1'b0; return; end
      @(negedge i_sysclk);
    end
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    chk("bvalid_after_last_w", S_AXI_BVALID, 1);
    S_AXI_BREADY = 1'b1;
    n = 0;
    while (!S_AXI_BVALID && n < 50) begin @(negedge i_sysclk); n++; end
    if (!S_AXI_BVALID) begin tmo("b_handshake"); S_AXI_BREADY = 1'b0; return; end
    resp = S_AXI_BRESP;
    bid  = S_AXI_BID;
    @(negedge i_sysclk);
    S_AXI_BREADY = 1'b0;
    chk("awready_after_b", S_AXI_AWREADY, 1);
  endtask

  // One full read burst into rbuf/rrbuf/rlbuf. stall[c] = 1 drops RREADY in loop cycle c.
  task automatic do_read(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [15:0] stall);
    int n;
    int beat;
    int cyc;
    logic stalled;
    logic [31:0] held;
    logic held_last;
    @(negedge i_sysclk);
    S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len;
    S_AXI_ARSIZE = size; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 50) begin @(negedge i_sysclk); n++; end
    if (!S_AXI_ARREADY) begin tmo("ar_handshake"); S_AXI_ARVALID = 1'b0; return; end
    @(negedge i_sysclk);
    S_AXI_ARVALID = 1'b0;
    chk("rvalid_after_ar", S_AXI_RVALID, 1);
    rid_got = S_AXI_RID;
    beat = 0; cyc = 0; stalled = 1'b0; held = '0; held_last = 1'b0;
    while (beat <= int'(len) && cyc < 200) begin
      if (S_AXI_RVALID) begin
        if (stall[cyc % 16]) begin
          S_AXI_RREADY = 1'b0;
          held = S_AXI_RDATA; held_last = S_AXI_RLAST; stalled = 1'b1;
        end else begin
          S_AXI_RREADY = 1'b1;
          if (stalled) chk("rdata_stable_in_stall", {S_AXI_RLAST, S_AXI_RDATA}, {held_last, held});
          stalled = 1'b0;
          rbuf[beat] = S_AXI_RDATA; rrbuf[beat] = S_AXI_RRESP; rlbuf[beat] = S_AXI_RLAST;
          beat++;
        end
      end else begin
        S_AXI_RREADY = 1'b0;
      end
      @(negedge i_sysclk);
      cyc++;
    end
    S_AXI_RREADY = 1'b0;
    if (beat <= int'(len)) tmo("r_beats");
    else chk("arready_after_last_r", S_AXI_ARREADY, 1);
  endtask

  task automatic chk_read(input string nm, input int nbeats, input logic [1:0] resp,
                          input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int b = 0; b < nbeats; b++) begin
      chk($sformatf("%s_data%0d", nm, b), rbuf[b], e[b]);
      chk($sformatf("%s_resp%0d", nm, b), rrbuf[b], resp);
      chk($sformatf("%s_last%0d", nm, b), rlbuf[b], (b == nbeats - 1));
    end
  endtask

  vec_t vecs [6];
  logic [1:0] resp;
  logic [0:0] bid;

  initial begin
    vecs[0] = '{32'h0000_0100, 32'h1122_3344, 4'hF, 32'h0000_0100, 32'h1122_3344};
    vecs[1] = '{32'h0000_0100, 32'hDEAD_BEEF, 4'h3, 32'h0000_0100, 32'h1122_BEEF};
    vecs[2] = '{32'h0000_0100, 32'hCAFE_0000, 4'h8, 32'h4000_0100, 32'hCA22_BEEF};
    vecs[3] = '{32'h8000_0104, 32'h5566_7788, 4'hF, 32'h0000_0104, 32'h5566_7788};
    vecs[4] = '{32'h0000_0104, 32'hFFFF_FFFF, 4'h0, 32'h0000_0104, 32'h5566_7788};
    vecs[5] = '{32'h0000_03FC, 32'h1234_5678, 4'hF, 32'hFFFF_F3FC, 32'h1234_5678};

    // Reset state, then the ready signals rise one cycle after release.
    repeat (3) @(negedge i_sysclk);
    chk("reset_outputs",
        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST,
         S_AXI_BID, S_AXI_BRESP, S_AXI_RID, S_AXI_RRESP, S_AXI_RDATA}, 64'd0);
    i_sysrst = 1'b0;
    @(negedge i_sysclk);
    chk("ready_after_reset", {S_AXI_AWREADY, S_AXI_ARREADY}, 2'b11);

    // INCR write of four beats, then read them back.
    wbuf[0] = 32'hA0; wbuf[1] = 32'hA1; wbuf[2] = 32'hA2; wbuf[3] = 32'hA3;
    do_write(1'b1, 32'h4000_0010, 8'd3, 3'd2, 2'b01, 4'hF, -1, resp, bid);
    chk("incr_bresp", resp, 2'b00);
    chk("incr_bid", bid, 1'b1);
    do_read(1'b1, 32'h0000_0010, 8'd3, 3'd2, 2'b01, 16'h0000);
    chk("incr_rid", rid_got, 1'b1);
    chk_read("incr", 4, 2'b00, 32'hA0, 32'hA1, 32'hA2, 32'hA3);

    // Single-beat byte-strobe and aliasing vectors.
    for (int i = 0; i < 6; i++) begin
      wbuf[0] = vecs[i].wdata;
      do_write(1'b0, vecs[i].waddr, 8'd0, 3'd2, 2'b01, vecs[i].strb, -1, resp, bid);
      chk($sformatf("vec%0d_bresp", i), resp, 2'b00);
      do_read(1'b0, vecs[i].raddr, 8'd0, 3'd2, 2'b01, 16'h0000);
      chk($sformatf("vec%0d_rdata", i), rbuf[0], vecs[i].exp);
      chk($sformatf("vec%0d_rlast", i), rlbuf[0], 1'b1);
    end

    // Read with RREADY toggling. The data must hold during each stall.
    do_read(1'b0, 32'h0000_0010, 8'd3, 3'd2, 2'b01, 16'hAAAA);
    chk("stall_rid", rid_got, 1'b0);
    chk_read("stall", 4, 2'b00, 32'hA0, 32'hA1, 32'hA2, 32'hA3);

    // Reserved burst type: SLVERR, and memory is not touched.
    wbuf[0] = 32'hBAD0; wbuf[1] = 32'hBAD1;
    do_write(1'b0, 32'h0000_0010, 8'd1, 3'd2, 2'b11, 4'hF, -1, resp, bid);
    chk("rsvd_bresp", resp, 2'b10);
    do_read(1'b0, 32'h0000_0010, 8'd1, 3'd2, 2'b01, 16'h0000);
    chk_read("rsvd_mem", 2, 2'b00, 32'hA0, 32'hA1, 32'h0, 32'h0);

    // Narrow read size: SLVERR and zero data on every beat.
    do_read(1'b0, 32'h0000_0010, 8'd3, 3'd1, 2'b01, 16'h0000);
    chk_read("size_err", 4, 2'b10, 32'h0, 32'h0, 32'h0, 32'h0);

    // Early WLAST: all four beats are still taken and written, and BRESP is SLVERR.
    wbuf[0] = 32'hC0; wbuf[1] = 32'hC1; wbuf[2] = 32'hC2; wbuf[3] = 32'hC3;
    do_write(1'b0, 32'h0000_0020, 8'd3, 3'd2, 2'b01, 4'hF, 1, resp, bid);
    chk("wlast_bresp", resp, 2'b10);
    do_read(1'b0, 32'h0000_0020, 8'd3, 3'd2, 2'b01, 16'h0000);
    chk_read("wlast_mem", 4, 2'b00, 32'hC0, 32'hC1, 32'hC2, 32'hC3);

    // FIXED burst: every beat goes to the same word, so the last beat is the one kept.
    wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3;
    do_write(1'b0, 32'h0000_0030, 8'd2, 3'd2, 2'b00, 4'hF, -1, resp, bid);
    chk("fixed_bresp", resp, 2'b00);
    do_read(1'b0, 32'h0000_0030, 8'd0, 3'd2, 2'b01, 16'h0000);
    chk("fixed_rdata", rbuf[0], 32'h3);

    // WRAP len=3 at 0x08. The preload is visible only when WRAP is not supported.
    wbuf[0] = 32'hE0; wbuf[1] = 32'hE1; wbuf[2] = 32'hE2; wbuf[3] = 32'hE3;
    do_write(1'b0, 32'h0000_0000, 8'd3, 3'd2, 2'b01, 4'hF, -1, resp, bid);
    chk("wrap_preload_bresp", resp, 2'b00);
    wbuf[0] = 32'hD0; wbuf[1] = 32'hD1; wbuf[2] = 32'hD2; wbuf[3] = 32'hD3;
    do_write(1'b0, 32'h0000_0008, 8'd3, 3'd2, 2'b10, 4'hF, -1, resp, bid);
`ifdef AXI_S_WRAP_BURST_EN
    chk("wrap_bresp", resp, 2'b00);
    do_read(1'b0, 32'h0000_0000, 8'd3, 3'd2, 2'b01, 16'h0000);
    chk_read("wrap_mem", 4, 2'b00, 32'hD2, 32'hD3, 32'hD0, 32'hD1);
    do_read(1'b0, 32'h0000_0008, 8'd3, 3'd2, 2'b10, 16'h0000);
    chk_read("wrap_read", 4, 2'b00, 32'hD0, 32'hD1, 32'hD2, 32'hD3);
`else
    chk("wrap_bresp", resp, 2'b10);
    do_read(1'b0, 32'h0000_0000, 8'd3, 3'd2, 2'b01, 16'h0000);
    chk_read("wrap_mem", 4, 2'b00, 32'hE0, 32'hE1, 32'hE2, 32'hE3);
    do_read(1'b0, 32'h0000_0008, 8'd3, 3'd2, 2'b10, 16'h0000);
    chk_read("wrap_read", 4, 2'b10, 32'h0, 32'h0, 32'h0, 32'h0);
`endif

    // Reset in the middle of a write burst. The two beats already written stay in memory.
    @(negedge i_sysclk);
    S_AXI_AWID = 1'b0; S_AXI_AWADDR = 32'h0000_0180; S_AXI_AWLEN = 8'd3;
    S_AXI_AWSIZE = 3'd2; S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 1'b1;
    chk("mid_awready", S_AXI_AWREADY, 1'b1);
    @(negedge i_sysclk);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = 32'hF0; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b1;
    @(negedge i_sysclk);
    S_AXI_WDATA = 32'hF1;
    @(negedge i_sysclk);
    S_AXI_WVALID = 1'b0;
    i_sysrst = 1'b1;
    @(negedge i_sysclk);
    chk("mid_reset_outputs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 3'b000);
    i_sysrst = 1'b0;
    @(negedge i_sysclk);
    chk("mid_awready_after", S_AXI_AWREADY, 1'b1);
    do_read(1'b0, 32'h0000_0180, 8'd1, 3'd2, 2'b01, 16'h0000);
    chk_read("mid_mem", 2, 2'b00, 32'hF0, 32'hF1, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
